// File: rtl/mmcm_phase_step_ctrl.sv
// Steps the MMCM fine phase-shift port by a signed count per request and tracks position mod one 5 MHz period.
// Per step: 1 PSEN clock + PSDONE delay + GAP_CYC idle clocks; requests are taken only while req_ready_o is high.
module mmcm_phase_step_ctrl #(
   parameter int STEP_W        = 8,
   parameter int STEPS_PER_REV = 6720,
   parameter int POS_W         = 13,
   parameter int TIMEOUT_CYC   = 64,
   parameter int GAP_CYC       = 2
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     locked_i,
   input  logic                     req_valid_i,
   input  logic signed [STEP_W-1:0] req_steps_i,
   output logic                     req_ready_o,
   input  logic                     clr_err_i,
   output logic                     psen_o,
   output logic                     psincdec_o,
   input  logic                     psdone_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic [POS_W-1:0]         phase_pos_o
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [POS_W-1:0] POS_MAX  = POS_W'(STEPS_PER_REV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE,
      S_WAIT,
      S_GAP,
      S_DONE,
      S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   rem_q, rem_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                psen_q, psen_d;
   logic                psincdec_q, psincdec_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [STEP_W-1:0]   req_mag;
   logic                req_acc;

   // Two's-complement negate: the most negative request maps to 2^(STEP_W-1).
   assign req_mag = req_steps_i[STEP_W-1] ? (~req_steps_i + STEP_W'(1))
                                          : req_steps_i;

   assign req_ready_o = (state_q == S_IDLE) & locked_i & ~err_q;
   assign req_acc     = req_valid_i & req_ready_o;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      pos_d      = pos_q;
      gap_d      = gap_q;
      tmo_d      = '0;
      psen_d     = 1'b0;
      psincdec_d = psincdec_q;
      done_d     = 1'b0;
      err_d      = err_q & ~clr_err_i;

      case (state_q)
         S_IDLE: begin
            if (req_acc) begin
               rem_d = req_mag;
               if (req_mag == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = S_PULSE;
                  psen_d     = 1'b1;
                  psincdec_d = ~req_steps_i[STEP_W-1];
               end
            end
         end

         // The PSEN clock counts as the first clock of the PSDONE wait window.
         S_PULSE: begin
            state_d = S_WAIT;
            tmo_d   = tmo_q + TMO_W'(1);
         end

         S_WAIT: begin
            if (psdone_i) begin
               if (psincdec_q) begin
                  pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
               end else begin
                  pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
               end
               rem_d = rem_q - STEP_W'(1);
               if (rem_q == STEP_W'(1)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (GAP_CYC == 0) begin
                  state_d = S_PULSE;
                  psen_d  = 1'b1;
               end else begin
                  state_d = S_GAP;
                  gap_d   = '0;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_PULSE;
               psen_d  = 1'b1;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end

         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Losing lock overrides everything; steps already completed stay counted.
      if ((state_q != S_IDLE) && !locked_i) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         psen_d  = 1'b0;
         done_d  = 1'b0;
         pos_d   = pos_q;
         rem_d   = '0;
      end

      if (state_d == S_IDLE) begin
         psincdec_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         rem_q      <= '0;
         pos_q      <= '0;
         tmo_q      <= '0;
         gap_q      <= '0;
         psen_q     <= 1'b0;
         psincdec_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         pos_q      <= pos_d;
         tmo_q      <= tmo_d;
         gap_q      <= gap_d;
         psen_q     <= psen_d;
         psincdec_q <= psincdec_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign psen_o      = psen_q;
   assign psincdec_o  = psincdec_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign busy_o      = (state_q != S_IDLE);
   assign phase_pos_o = pos_q;

endmodule

// File: tb/tb_mmcm_phase_step_ctrl.sv
// Directed bench for mmcm_phase_step_ctrl: step sequencing, wrap, timeout, lock loss, zero/min requests, reset.
module tb_mmcm_phase_step_ctrl;

   localparam int STEP_W        = 8;
   localparam int STEPS_PER_REV = 6720;
   localparam int POS_W         = 13;
   localparam int TIMEOUT_CYC   = 64;
   localparam int GAP_CYC       = 2;

   logic                     clk_i = 1'b0;
   logic                     reset_i;
   logic                     locked_i;
   logic                     req_valid_i;
   logic signed [STEP_W-1:0] req_steps_i;
   logic                     req_ready_o;
   logic                     clr_err_i;
   logic                     psen_o;
   logic                     psincdec_o;
   logic                     psdone_i;
   logic                     busy_o;
   logic                     done_o;
   logic                     err_o;
   logic [POS_W-1:0]         phase_pos_o;

   int n_vec = 0;
   int n_err = 0;

   mmcm_phase_step_ctrl #(
      .STEP_W        (STEP_W),
      .STEPS_PER_REV (STEPS_PER_REV),
      .POS_W         (POS_W),
      .TIMEOUT_CYC   (TIMEOUT_CYC),
      .GAP_CYC       (GAP_CYC)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .locked_i    (locked_i),
      .req_valid_i (req_valid_i),
      .req_steps_i (req_steps_i),
      .req_ready_o (req_ready_o),
      .clr_err_i   (clr_err_i),
      .psen_o      (psen_o),
      .psincdec_o  (psincdec_o),
      .psdone_i    (psdone_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .phase_pos_o (phase_pos_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Issues one request and answers every PSEN with PSDONE dly clocks later.
   task automatic run_req(input string tag, input logic [STEP_W-1:0] steps, input int dly,
                          input logic exp_dir, input int exp_n, input int exp_pos);
      int  psen_at;
      int  npsen;
      int  ndone;
      int  nbad;
      bit  fin;
      chk({tag, ".ready"}, {31'd0, req_ready_o}, 32'd1);
      req_valid_i = 1'b1;
      req_steps_i = steps;
      tick();
      req_valid_i = 1'b0;
      psen_at = -1000;
      npsen   = 0;
      ndone   = 0;
      nbad    = 0;
      fin     = 1'b0;
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         psdone_i = (cyc == psen_at + dly);
         if (psen_o) begin
            if (npsen > 0 && (cyc - psen_at) != (dly + GAP_CYC + 1)) nbad++;
            psen_at = cyc;
            npsen++;
         end
         if (busy_o && psincdec_o !== exp_dir) nbad++;
         if (done_o) ndone++;
         if (ndone > 0 && !busy_o) fin = 1'b1;
         else tick();
      end
      psdone_i = 1'b0;
      chk({tag, ".npsen"}, npsen, exp_n);
      chk({tag, ".ndone"}, ndone, 1);
      chk({tag, ".timing_dir"}, nbad, 0);
      chk({tag, ".pos"}, {19'd0, phase_pos_o}, exp_pos);
   endtask

   int npsen;
   int ndone;

   initial begin
      reset_i     = 1'b1;
      locked_i    = 1'b1;
      req_valid_i = 1'b0;
      req_steps_i = '0;
      clr_err_i   = 1'b0;
      psdone_i    = 1'b0;
      repeat (3) tick();
      chk("rst.psen", {31'd0, psen_o}, 0);
      chk("rst.busy", {31'd0, busy_o}, 0);
      chk("rst.done", {31'd0, done_o}, 0);
      chk("rst.err", {31'd0, err_o}, 0);
      chk("rst.pos", {19'd0, phase_pos_o}, 0);
      reset_i = 1'b0;
      tick();

      // +3 with 12-clock PSDONE, then walk down to 1 and wrap below zero
      run_req("p3", 8'sd3, 12, 1'b1, 3, 3);
      run_req("m2", -8'sd2, 5, 1'b0, 2, 1);
      run_req("m3wrap", -8'sd3, 4, 1'b0, 3, 6718);
      run_req("p3wrap", 8'sd3, 7, 1'b1, 3, 1);

      // +2 with PSDONE never arriving
      chk("to.ready", {31'd0, req_ready_o}, 1);
      req_valid_i = 1'b1;
      req_steps_i = 8'sd2;
      tick();
      req_valid_i = 1'b0;
      chk("to.psen", {31'd0, psen_o}, 1);
      npsen = 0;
      ndone = 0;
      for (int k = 1; k <= TIMEOUT_CYC - 1; k++) begin
         tick();
         npsen += int'(psen_o);
         ndone += int'(done_o);
      end
      chk("to.err_early", {31'd0, err_o}, 0);
      tick();
      chk("to.err", {31'd0, err_o}, 1);
      chk("to.ready_err", {31'd0, req_ready_o}, 0);
      tick();
      npsen += int'(psen_o);
      ndone += int'(done_o);
      chk("to.busy", {31'd0, busy_o}, 0);
      chk("to.ready_idle", {31'd0, req_ready_o}, 0);
      chk("to.npsen", npsen, 0);
      chk("to.ndone", ndone, 0);
      chk("to.pos", {19'd0, phase_pos_o}, 1);
      clr_err_i = 1'b1;
      tick();
      clr_err_i = 1'b0;
      chk("to.err_clr", {31'd0, err_o}, 0);
      chk("to.ready_clr", {31'd0, req_ready_o}, 1);

      // +5 from 0, lock dropped after the second PSDONE
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      chk("lk.pos0", {19'd0, phase_pos_o}, 0);
      req_valid_i = 1'b1;
      req_steps_i = 8'sd5;
      tick();
      req_valid_i = 1'b0;
      chk("lk.psen0", {31'd0, psen_o}, 1);
      repeat (3) tick();
      psdone_i = 1'b1;
      tick();
      psdone_i = 1'b0;
      chk("lk.pos1", {19'd0, phase_pos_o}, 1);
      repeat (2) tick();
      chk("lk.psen1", {31'd0, psen_o}, 1);
      repeat (3) tick();
      psdone_i = 1'b1;
      tick();
      psdone_i = 1'b0;
      chk("lk.pos2", {19'd0, phase_pos_o}, 2);
      locked_i = 1'b0;
      tick();
      chk("lk.err", {31'd0, err_o}, 1);
      chk("lk.busy", {31'd0, busy_o}, 0);
      chk("lk.psen", {31'd0, psen_o}, 0);
      npsen = 0;
      ndone = int'(done_o);
      for (int k = 0; k < 10; k++) begin
         tick();
         npsen += int'(psen_o);
         ndone += int'(done_o);
      end
      chk("lk.npsen", npsen, 0);
      chk("lk.ndone", ndone, 0);
      chk("lk.pos", {19'd0, phase_pos_o}, 2);
      locked_i  = 1'b1;
      clr_err_i = 1'b1;
      tick();
      clr_err_i = 1'b0;

      // zero-step request, then the most negative request
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      req_valid_i = 1'b1;
      req_steps_i = 8'sd0;
      tick();
      req_valid_i = 1'b0;
      chk("z.done", {31'd0, done_o}, 1);
      chk("z.psen", {31'd0, psen_o}, 0);
      tick();
      chk("z.done_off", {31'd0, done_o}, 0);
      chk("z.busy", {31'd0, busy_o}, 0);
      run_req("m128", 8'h80, 2, 1'b0, 128, STEPS_PER_REV - 128);

      // stray PSDONE in IDLE and in the PULSE clock
      psdone_i = 1'b1;
      repeat (2) tick();
      psdone_i = 1'b0;
      chk("st.idle_pos", {19'd0, phase_pos_o}, STEPS_PER_REV - 128);
      psdone_i    = 1'b1;
      req_valid_i = 1'b1;
      req_steps_i = 8'sd1;
      tick();
      req_valid_i = 1'b0;
      chk("st.psen", {31'd0, psen_o}, 1);
      tick();
      psdone_i = 1'b0;
      chk("st.pulse_pos", {19'd0, phase_pos_o}, STEPS_PER_REV - 128);
      repeat (3) tick();
      psdone_i = 1'b1;
      tick();
      psdone_i = 1'b0;
      chk("st.pos", {19'd0, phase_pos_o}, STEPS_PER_REV - 127);
      chk("st.done", {31'd0, done_o}, 1);
      tick();

      // reset in the middle of a request
      req_valid_i = 1'b1;
      req_steps_i = 8'sd3;
      tick();
      req_valid_i = 1'b0;
      chk("mr.psen_pre", {31'd0, psen_o}, 1);
      reset_i = 1'b1;
      tick();
      chk("mr.psen", {31'd0, psen_o}, 0);
      chk("mr.psincdec", {31'd0, psincdec_o}, 0);
      chk("mr.busy", {31'd0, busy_o}, 0);
      chk("mr.done", {31'd0, done_o}, 0);
      chk("mr.err", {31'd0, err_o}, 0);
      chk("mr.pos", {19'd0, phase_pos_o}, 0);
      reset_i = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
